// File: rtl/ewb_drain_if.sv
// Bundle between the eviction write buffer, the memory arbiter and the physical memory burst port.
// The drain side uses the master modport; the buffer/arbiter/memory side uses slave.
interface ewb_drain_if #(
   parameter int width      = 256,
   parameter int beat_width = 64,
   parameter int addr_width = 32
);
   // Handshakes: a line moves when ewb_valid_i && ewb_yumi_o in the same cycle (yumi never
   // without valid); the memory port is owned while arb_req_o && arb_gnt_i; a beat moves
   // when pmem_write_o && pmem_resp_i, and wdata/address hold until that cycle.
   logic                  ewb_valid_i;
   logic [width-1:0]      ewb_data_i;
   logic [addr_width-1:0] ewb_addr_i;
   logic                  ewb_yumi_o;
   logic                  arb_req_o;
   logic                  arb_gnt_i;
   logic [addr_width-1:0] pmem_address_o;
   logic [beat_width-1:0] pmem_wdata_o;
   logic                  pmem_write_o;
   logic                  pmem_resp_i;

   modport master (
      input  ewb_valid_i, ewb_data_i, ewb_addr_i, arb_gnt_i, pmem_resp_i,
      output ewb_yumi_o, arb_req_o, pmem_address_o, pmem_wdata_o, pmem_write_o
   );

   modport slave (
      output ewb_valid_i, ewb_data_i, ewb_addr_i, arb_gnt_i, pmem_resp_i,
      input  ewb_yumi_o, arb_req_o, pmem_address_o, pmem_wdata_o, pmem_write_o
   );
endinterface

// File: rtl/ewb_drain.sv
// Drains L2 victim lines from the eviction write buffer into physical memory as beat bursts.
// Define EWB_DRAIN_PERF_EN to build the lines_written/stall_cycles performance counters.
module ewb_drain #(
   parameter int width      = 256,
   parameter int beat_width = 64,
   parameter int addr_width = 32
) (
   input  logic        clk,
   input  logic        rst_n,
   ewb_drain_if.master bus,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] lines_written_o,
   output logic [31:0] stall_cycles_o,
   output logic [1:0]  state_o
);

   localparam int beats = width / beat_width;
   localparam int cnt_w = (beats > 1) ? $clog2(beats) : 1;
   localparam int off_w = $clog2(width / 8);
   localparam logic [addr_width-1:0] addr_mask = {{(addr_width-off_w){1'b1}}, {off_w{1'b0}}};
   localparam logic [cnt_w-1:0] last_beat = cnt_w'(beats - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t                               state_r, state_nxt;
   logic [beats-1:0][beat_width-1:0]     line_r;
   logic [addr_width-1:0]                addr_r;
   logic [cnt_w-1:0]                     beat_cnt;
   logic                                 accept;
   logic                                 beat_ack;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= IDLE;
      else        state_r <= state_nxt;
   end

   // rst_n gates the IDLE outputs so req/yumi are 0 while reset is held.
   always_comb begin
      state_nxt          = state_r;
      bus.ewb_yumi_o     = 1'b0;
      bus.arb_req_o      = 1'b0;
      bus.pmem_write_o   = 1'b0;
      bus.pmem_address_o = '0;
      bus.pmem_wdata_o   = '0;
      busy_o             = 1'b0;
      done_o             = 1'b0;
      accept             = 1'b0;
      beat_ack           = 1'b0;
      case (state_r)
         IDLE: begin
            bus.arb_req_o  = bus.ewb_valid_i & rst_n;
            accept         = bus.ewb_valid_i & bus.arb_gnt_i & rst_n;
            bus.ewb_yumi_o = accept;
            if (accept) state_nxt = BURST;
         end
         BURST: begin
            bus.arb_req_o      = 1'b1;
            bus.pmem_write_o   = 1'b1;
            busy_o             = 1'b1;
            bus.pmem_address_o = addr_r;
            bus.pmem_wdata_o   = line_r[beat_cnt];
            beat_ack           = bus.pmem_resp_i;
            if (beat_ack && (beat_cnt == last_beat)) state_nxt = DONE;
         end
         DONE: begin
            done_o    = 1'b1;
            busy_o    = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // The held line makes this block a one-entry extension of the eviction queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_r   <= '0;
         addr_r   <= '0;
         beat_cnt <= '0;
      end else if (accept) begin
         line_r   <= bus.ewb_data_i;
         addr_r   <= bus.ewb_addr_i & addr_mask;
         beat_cnt <= '0;
      end else if (beat_ack) begin
         beat_cnt <= beat_cnt + cnt_w'(1);
      end
   end

   assign state_o = state_r;

`ifdef EWB_DRAIN_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lines_written_o <= '0;
         stall_cycles_o  <= '0;
      end else begin
         if (done_o && (lines_written_o != '1))
            lines_written_o <= lines_written_o + 32'd1;
         if ((state_r == BURST) && !bus.pmem_resp_i && (stall_cycles_o != '1))
            stall_cycles_o <= stall_cycles_o + 32'd1;
      end
   end
`else
   assign lines_written_o = '0;
   assign stall_cycles_o  = '0;
`endif

endmodule
